cla_seq_adder: RTL
==================

CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; legal values are multiples of 4, from 4 to 64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the operand request is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept an operand request.
REQ-006 SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-007 SHALL have port cin, input, 1 bit: carry-in.
REQ-008 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port sum, output, WIDTH bits: the result.
REQ-011 SHALL have port cout, output, 1 bit: carry-out of the MSB nibble.
REQ-012 SHALL have port busy, output, 1 bit: high in RUN.

Function
REQ-013 SHALL compute {cout,sum} = a + b + cin (mod 2^(WIDTH+1)) by sequencing one 4-bit CLA slice across NIB = WIDTH/4 nibbles, LSB nibble first.
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
- IDLE -> RUN on in_valid && in_ready.
- RUN -> DONE after nibble NIB-1.
- DONE -> IDLE on out_valid && out_ready.
REQ-015 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE; both are decoded from registered state only.
REQ-016 SHALL, on the accept edge, register a, b and cin into internal registers, clear the nibble index to 0 and clear sum.
- Input changes after the accept edge SHALL NOT affect the result.
REQ-017 SHALL, on each RUN edge:
- write the CLA slice sum into sum[4*idx+3:4*idx];
- register the slice carry-out as the carry into the next nibble;
- increment idx.
REQ-018 SHALL assert out_valid exactly NIB clock edges after the accept edge (4 cycles for WIDTH=16).
REQ-019 SHALL hold sum and cout stable in DONE while out_ready=0, for any duration.
REQ-020 SHALL ignore in_valid outside IDLE; a request is never dropped silently, since in_ready=0 outside IDLE.
REQ-021 SHALL return to IDLE on the edge where DONE sees out_ready=1, so back-to-back throughput is one operation per NIB+2 cycles.
REQ-022 SHALL drive cout from the registered final carry, updated only on the last RUN edge.
REQ-023 SHALL exercise the full carry chain when WIDTH=4 (NIB=1): a single RUN cycle.

Reset
REQ-024 SHALL, while rst_n=0 (asynchronous), hold:
- state=IDLE, idx=0, carry=0, sum=0, cout=0;
- out_valid=0, busy=0, in_ready=1.
REQ-025 SHALL abort an in-flight RUN or DONE on rst_n assertion with no output pulse; the first request after release SHALL be computed correctly.

Configuration
REQ-026 SHALL support macro CLA_SEQ_SUB_EN.
- Defined: the block adds input port sub (1 bit), captured at accept. When sub=1, the block computes a + ~b + 1, ignoring cin. cout=1 means no borrow.
- Undefined: the sub port is absent and behaviour is pure addition per REQ-013.

Structure
REQ-027 SHALL place the FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the nibble width constant (4) in shared package cla_seq_pkg.
REQ-028 SHALL instantiate the codebase's existing 4-bit dataflow CLA module cla_df as its only sub-module, with nibble muxing done in this block.

Verification
REQ-029 SHALL cover: reset, then a=0x0000, b=0x0000, cin=0.
- Required: in_ready=1 during reset.
- Required: out_valid 4 cycles after accept, sum=0x0000, cout=0.
REQ-030 SHALL cover: a=0xFFFF, b=0x0001, cin=0.
- Required: sum=0x0000, cout=1 (carry propagates through all four nibbles).
REQ-031 SHALL cover: a=0x1234, b=0x4321, cin=1, with inputs changed to 0xAAAA/0x5555 one cycle after accept.
- Required: sum=0x5556, cout=0.
REQ-032 SHALL cover: a=0x8000, b=0x8000, cin=0, with out_ready=0 for 5 cycles.
- Required: out_valid held, sum=0x0000, cout=1 stable, in_ready=0 throughout.
- Required: IDLE on the edge after out_ready=1.
REQ-033 SHALL cover: rst_n pulsed low during RUN (idx=2), then a=0x00F0, b=0x0010, cin=0.
- Required: no out_valid for the aborted request.
- Required: next result sum=0x0100, cout=0.
REQ-034 SHALL cover, with CLA_SEQ_SUB_EN defined:
- a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0;
- a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// Shared FSM encodings and slice width for the sequential nibble-serial CLA adder.
package cla_seq_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_state_t;

  localparam int NIB_W = 4;
endpackage

// File: rtl/cla_df.sv
// 4-bit carry-lookahead adder slice, pure dataflow.
// Combinational; no backpressure.
module cla_df (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s    = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/cla_seq_adder.sv
// Nibble-serial adder: one cla_df slice swept LSB-first; CLA_SEQ_SUB_EN adds a subtract mode.
// Latency: out_valid NIB edges after accept; result held in DONE until out_ready.
// Backpressure: in_ready only in IDLE, one operation per NIB+2 cycles back-to-back.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NIB  = WIDTH / NIB_W;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  cla_state_t state, state_nxt;

  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] s_nib;
  logic             c_nib;
  logic             last;
  logic             accept;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (idx == IDXW'(NIB - 1));

  assign a_nib = a_r[NIB_W*idx +: NIB_W];
  assign b_nib = b_r[NIB_W*idx +: NIB_W];

  cla_df u_cla (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .s    (s_nib),
    .cout (c_nib)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      carry  <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      idx   <= '0;
      sum_r <= '0;
`ifdef CLA_SEQ_SUB_EN
      // Subtract as a + ~b + 1; cin is deliberately ignored in this mode.
      b_r   <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
`else
      b_r   <= b;
      carry <= cin;
`endif
    end else if (state == RUN) begin
      sum_r[NIB_W*idx +: NIB_W] <= s_nib;
      carry <= c_nib;
      // Park idx at 0 after the last nibble so the slice mux never indexes past WIDTH.
      idx   <= last ? '0 : idx + IDXW'(1);
      if (last) cout_r <= c_nib;
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
endmodule
